id_ex_hazard_reg: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline.
- Captures decoded control, operands and register addresses from ID each cycle, and supplies ID_EX_RegisterRs/Rt to the forwarding unit.
- Detects a load followed by a dependent instruction, inserts one bubble into EX and holds PC and IF/ID.
- Supports a branch/jump flush and a global freeze for data-memory wait states.

---
 rtl/id_ex_hazard_reg_pkg.sv | 27 ++
 rtl/id_ex_hazard_reg_if.sv | 54 +++++
 rtl/id_ex_hazard_reg_load_use_detect.sv | 18 +
 rtl/id_ex_hazard_reg.sv | 108 ++++++++++
 tb/tb_id_ex_hazard_reg.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared pipeline definitions for the ID/EX register and its hazard logic:
// the zero-register constant, ALUOp encodings and the packed control bundle.
package pipe_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_LOGIC = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    RegWrite;
    logic    MemRead;
    logic    MemWrite;
    logic    MemtoReg;
    logic    ALUSrc;
    logic    RegDst;
    alu_op_e ALUOp;
  } id_ctrl_t;

  // A bubble carries no side effects: nothing written, nothing read from memory.
  localparam id_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// Decode-to-execute bundle: ID-stage fields in, registered ID_EX fields out.
// master = decode side (drives ID_*), slave = the ID/EX register.
interface id_ex_hazard_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] IF_ID_RegisterRs;
  logic [REG_AW-1:0] IF_ID_RegisterRt;
  logic [REG_AW-1:0] IF_ID_RegisterRd;
  logic              ID_RegWrite;
  logic              ID_MemRead;
  logic              ID_MemWrite;
  logic              ID_MemtoReg;
  logic              ID_ALUSrc;
  logic              ID_RegDst;
  logic [1:0]        ID_ALUOp;
  logic [DATA_W-1:0] ID_RsData;
  logic [DATA_W-1:0] ID_RtData;
  logic [DATA_W-1:0] ID_Imm;

  logic              ID_EX_RegWrite;
  logic              ID_EX_MemRead;
  logic              ID_EX_MemWrite;
  logic              ID_EX_MemtoReg;
  logic              ID_EX_ALUSrc;
  logic              ID_EX_RegDst;
  logic [1:0]        ID_EX_ALUOp;
  logic [REG_AW-1:0] ID_EX_RegisterRs;
  logic [REG_AW-1:0] ID_EX_RegisterRt;
  logic [REG_AW-1:0] ID_EX_RegisterRd;
  logic [DATA_W-1:0] ID_EX_RsData;
  logic [DATA_W-1:0] ID_EX_RtData;
  logic [DATA_W-1:0] ID_EX_Imm;

  modport master (
    output IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_RegisterRd,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst,
           ID_ALUOp, ID_RsData, ID_RtData, ID_Imm,
    input  ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
           ID_EX_ALUSrc, ID_EX_RegDst, ID_EX_ALUOp,
           ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd,
           ID_EX_RsData, ID_EX_RtData, ID_EX_Imm
  );

  modport slave (
    input  IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_RegisterRd,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst,
           ID_ALUOp, ID_RsData, ID_RtData, ID_Imm,
    output ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
           ID_EX_ALUSrc, ID_EX_RegDst, ID_EX_ALUOp,
           ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd,
           ID_EX_RsData, ID_EX_RtData, ID_EX_Imm
  );
endinterface

// File: rtl/id_ex_hazard_reg_load_use_detect.sv
// Load-use hazard equation: a load in EX whose destination (Rt, never $0)
// is read as Rs or Rt by the instruction in ID. Purely combinational.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              hazard
);
  // Rt of the consumer is compared even for I-type instructions (conservative).
  assign hazard = ex_mem_read
               && (ex_rt != REG_AW'(REG_ZERO))
               && ((ex_rt == id_rs) || (ex_rt == id_rt));
endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush and freeze.
// Optional macro HAZARD_PERF_CNT_EN adds stall/flush event counters.
module id_ex_hazard_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               freeze_i,
  input  logic               flush_i,
  id_ex_hazard_reg_if.slave  bus,
  output logic               PCWrite_o,
  output logic               IF_ID_Write_o,
  output logic               stall_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        flush_cnt_o
`endif
);

  id_ctrl_t          id_ctrl;
  id_ctrl_t          ctrl_q;
  logic [REG_AW-1:0] rs_q, rt_q, rd_q;
  logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
  logic              hazard;

  always_comb begin
    id_ctrl          = CTRL_BUBBLE;
    id_ctrl.RegWrite = bus.ID_RegWrite;
    id_ctrl.MemRead  = bus.ID_MemRead;
    id_ctrl.MemWrite = bus.ID_MemWrite;
    id_ctrl.MemtoReg = bus.ID_MemtoReg;
    id_ctrl.ALUSrc   = bus.ID_ALUSrc;
    id_ctrl.RegDst   = bus.ID_RegDst;
    id_ctrl.ALUOp    = alu_op_e'(bus.ID_ALUOp);
  end

  load_use_detect #(.REG_AW(REG_AW)) u_detect (
    .ex_mem_read (ctrl_q.MemRead),
    .ex_rt       (rt_q),
    .id_rs       (bus.IF_ID_RegisterRs),
    .id_rt       (bus.IF_ID_RegisterRt),
    .hazard      (hazard)
  );

  // Flush does not release the front-end hold; the redirect is handled upstream.
  assign stall_o       = hazard && !freeze_i && !flush_i;
  assign PCWrite_o     = !freeze_i && !hazard;
  assign IF_ID_Write_o = !freeze_i && !hazard;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q    <= CTRL_BUBBLE;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else if (!freeze_i) begin
      if (flush_i || hazard) begin
        // Addresses cleared so forwarding can never match a bubble; data left as is.
        ctrl_q <= CTRL_BUBBLE;
        rs_q   <= '0;
        rt_q   <= '0;
        rd_q   <= '0;
      end else begin
        ctrl_q    <= id_ctrl;
        rs_q      <= bus.IF_ID_RegisterRs;
        rt_q      <= bus.IF_ID_RegisterRt;
        rd_q      <= bus.IF_ID_RegisterRd;
        rs_data_q <= bus.ID_RsData;
        rt_data_q <= bus.ID_RtData;
        imm_q     <= bus.ID_Imm;
      end
    end
  end

  assign bus.ID_EX_RegWrite   = ctrl_q.RegWrite;
  assign bus.ID_EX_MemRead    = ctrl_q.MemRead;
  assign bus.ID_EX_MemWrite   = ctrl_q.MemWrite;
  assign bus.ID_EX_MemtoReg   = ctrl_q.MemtoReg;
  assign bus.ID_EX_ALUSrc     = ctrl_q.ALUSrc;
  assign bus.ID_EX_RegDst     = ctrl_q.RegDst;
  assign bus.ID_EX_ALUOp      = ctrl_q.ALUOp;
  assign bus.ID_EX_RegisterRs = rs_q;
  assign bus.ID_EX_RegisterRt = rt_q;
  assign bus.ID_EX_RegisterRd = rd_q;
  assign bus.ID_EX_RsData     = rs_data_q;
  assign bus.ID_EX_RtData     = rt_data_q;
  assign bus.ID_EX_Imm        = imm_q;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_i && !freeze_i) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: hand-derived vector table, reset/counter sequences,
// and random stimulus against a behavioural pipeline-stage model.
module tb_id_ex_hazard_reg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  // control byte = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp[1:0]}
  localparam logic [7:0] CTL_LW  = 8'hD8;
  localparam logic [7:0] CTL_ADD = 8'h86;
  localparam logic [7:0] CTL_NOP = 8'h00;

  logic clk = 1'b0;
  logic rst, freeze, flush;
  logic pcw, ifw, stall;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  int checks = 0;
  int errors = 0;

  id_ex_hazard_reg_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  id_ex_hazard_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .freeze_i      (freeze),
    .flush_i       (flush),
    .bus           (bus),
    .PCWrite_o     (pcw),
    .IF_ID_Write_o (ifw),
    .stall_o       (stall)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: the instruction currently sitting in EX, plus event counts.
  logic [7:0]  m_ctrl;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [31:0] m_a, m_b, m_c;
  logic [31:0] m_scnt, m_fcnt;

  task automatic model_reset();
    m_ctrl = '0; m_rs = '0; m_rt = '0; m_rd = '0;
    m_a = '0; m_b = '0; m_c = '0;
    m_scnt = '0; m_fcnt = '0;
  endtask

  function automatic logic [118:0] model_vec();
    return {m_ctrl, m_rs, m_rt, m_rd, m_a, m_b, m_c};
  endfunction

  function automatic logic [118:0] dut_vec();
    return {bus.ID_EX_RegWrite, bus.ID_EX_MemRead, bus.ID_EX_MemWrite, bus.ID_EX_MemtoReg,
            bus.ID_EX_ALUSrc, bus.ID_EX_RegDst, bus.ID_EX_ALUOp,
            bus.ID_EX_RegisterRs, bus.ID_EX_RegisterRt, bus.ID_EX_RegisterRd,
            bus.ID_EX_RsData, bus.ID_EX_RtData, bus.ID_EX_Imm};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic frz, input logic fl, input logic [7:0] ctrl,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    freeze = frz; flush = fl;
    {bus.ID_RegWrite, bus.ID_MemRead, bus.ID_MemWrite, bus.ID_MemtoReg,
     bus.ID_ALUSrc, bus.ID_RegDst, bus.ID_ALUOp} = ctrl;
    bus.IF_ID_RegisterRs = rs; bus.IF_ID_RegisterRt = rt; bus.IF_ID_RegisterRd = rd;
    bus.ID_RsData = a; bus.ID_RtData = b; bus.ID_Imm = c;
  endtask

  // One pipeline cycle: drive at negedge, check front-end outputs, clock, check EX.
  task automatic do_cycle(input logic frz, input logic fl, input logic [7:0] ctrl,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          output logic s_act, output logic p_act);
    logic hz;
    @(negedge clk);
    drive(frz, fl, ctrl, rs, rt, rd, a, b, c);
    #1;
    hz = m_ctrl[6] && (m_rt != 5'd0) && (m_rt == rs || m_rt == rt);
    check("stall", stall, hz && !frz && !fl);
    check("pc_write", pcw, !frz && !hz);
    check("if_id_write", ifw, !frz && !hz);
    s_act = stall; p_act = pcw;
    @(posedge clk);
    if (!frz) begin
      if (hz && !fl) m_scnt++;
      if (fl) m_fcnt++;
      if (fl || hz) begin
        m_ctrl = '0; m_rs = '0; m_rt = '0; m_rd = '0;
      end else begin
        m_ctrl = ctrl; m_rs = rs; m_rt = rt; m_rd = rd;
        m_a = a; m_b = b; m_c = c;
      end
    end
    #1;
    check("ex_regs", dut_vec(), model_vec());
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_scnt);
    check("flush_cnt", flush_cnt, m_fcnt);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    freeze = 1'b0; flush = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic       frz, fl;
    logic [7:0] ctrl;
    logic [4:0] rs, rt, rd;
    logic       e_stall, e_pcw, e_regw, e_mr;
    logic [4:0] e_rs, e_rt, e_rd;
  } vec_t;

  vec_t tbl[26];

  initial begin
    logic s, p;
    // frz fl ctrl rs rt rd | stall pcw | regw mr rs rt rd (after edge)
    tbl[0]  = '{'0, '0, CTL_LW,  5'd1, 5'd2, 5'd0, '0, '1, '1, '1, 5'd1, 5'd2, 5'd0};
    tbl[1]  = '{'0, '0, CTL_ADD, 5'd2, 5'd4, 5'd3, '1, '0, '0, '0, 5'd0, 5'd0, 5'd0};
    tbl[2]  = '{'0, '0, CTL_ADD, 5'd2, 5'd4, 5'd3, '0, '1, '1, '0, 5'd2, 5'd4, 5'd3};
    tbl[3]  = '{'0, '0, CTL_LW,  5'd1, 5'd0, 5'd0, '0, '1, '1, '1, 5'd1, 5'd0, 5'd0};
    tbl[4]  = '{'0, '0, CTL_ADD, 5'd0, 5'd4, 5'd3, '0, '1, '1, '0, 5'd0, 5'd4, 5'd3};
    tbl[5]  = '{'0, '0, CTL_LW,  5'd1, 5'd2, 5'd0, '0, '1, '1, '1, 5'd1, 5'd2, 5'd0};
    tbl[6]  = '{'0, '0, CTL_ADD, 5'd5, 5'd6, 5'd3, '0, '1, '1, '0, 5'd5, 5'd6, 5'd3};
    tbl[7]  = '{'0, '0, CTL_LW,  5'd1, 5'd2, 5'd0, '0, '1, '1, '1, 5'd1, 5'd2, 5'd0};
    tbl[8]  = '{'1, '0, CTL_ADD, 5'd2, 5'd4, 5'd3, '0, '0, '1, '1, 5'd1, 5'd2, 5'd0};
    tbl[9]  = '{'1, '0, CTL_ADD, 5'd2, 5'd4, 5'd3, '0, '0, '1, '1, 5'd1, 5'd2, 5'd0};
    tbl[10] = '{'1, '0, CTL_ADD, 5'd2, 5'd4, 5'd3, '0, '0, '1, '1, 5'd1, 5'd2, 5'd0};
    tbl[11] = '{'0, '0, CTL_ADD, 5'd2, 5'd4, 5'd3, '1, '0, '0, '0, 5'd0, 5'd0, 5'd0};
    tbl[12] = '{'0, '0, CTL_ADD, 5'd2, 5'd4, 5'd3, '0, '1, '1, '0, 5'd2, 5'd4, 5'd3};
    tbl[13] = '{'0, '1, CTL_ADD, 5'd1, 5'd2, 5'd3, '0, '1, '0, '0, 5'd0, 5'd0, 5'd0};
    tbl[14] = '{'0, '0, CTL_LW,  5'd1, 5'd2, 5'd0, '0, '1, '1, '1, 5'd1, 5'd2, 5'd0};
    tbl[15] = '{'0, '1, CTL_ADD, 5'd2, 5'd4, 5'd3, '0, '0, '0, '0, 5'd0, 5'd0, 5'd0};
    tbl[16] = '{'0, '0, CTL_ADD, 5'd2, 5'd4, 5'd3, '0, '1, '1, '0, 5'd2, 5'd4, 5'd3};
    tbl[17] = '{'1, '1, CTL_LW,  5'd1, 5'd7, 5'd0, '0, '0, '1, '0, 5'd2, 5'd4, 5'd3};
    tbl[18] = '{'0, '0, CTL_LW,  5'd1, 5'd2, 5'd0, '0, '1, '1, '1, 5'd1, 5'd2, 5'd0};
    tbl[19] = '{'0, '0, CTL_LW,  5'd2, 5'd3, 5'd0, '1, '0, '0, '0, 5'd0, 5'd0, 5'd0};
    tbl[20] = '{'0, '0, CTL_LW,  5'd2, 5'd3, 5'd0, '0, '1, '1, '1, 5'd2, 5'd3, 5'd0};
    tbl[21] = '{'0, '0, CTL_ADD, 5'd3, 5'd1, 5'd4, '1, '0, '0, '0, 5'd0, 5'd0, 5'd0};
    tbl[22] = '{'0, '0, CTL_ADD, 5'd3, 5'd1, 5'd4, '0, '1, '1, '0, 5'd3, 5'd1, 5'd4};
    tbl[23] = '{'0, '0, CTL_LW,  5'd1, 5'd5, 5'd0, '0, '1, '1, '1, 5'd1, 5'd5, 5'd0};
    tbl[24] = '{'0, '0, CTL_ADD, 5'd1, 5'd5, 5'd6, '1, '0, '0, '0, 5'd0, 5'd0, 5'd0};
    tbl[25] = '{'0, '0, CTL_ADD, 5'd1, 5'd5, 5'd6, '0, '1, '1, '0, 5'd1, 5'd5, 5'd6};

    // Reset state
    rst = 1'b0;
    drive(1'b0, 1'b0, CTL_NOP, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    model_reset();
    #1 rst = 1'b1;
    #2;
    check("reset_ex_regs", dut_vec(), 119'd0);
    check("reset_pc_write", pcw, 1'b1);
    check("reset_if_id_write", ifw, 1'b1);
    check("reset_stall", stall, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_flush_cnt", flush_cnt, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 26; i++) begin
      do_cycle(tbl[i].frz, tbl[i].fl, tbl[i].ctrl, tbl[i].rs, tbl[i].rt, tbl[i].rd,
               $urandom, $urandom, $urandom, s, p);
      check($sformatf("row%0d_stall", i), s, tbl[i].e_stall);
      check($sformatf("row%0d_pc_write", i), p, tbl[i].e_pcw);
      check($sformatf("row%0d_regwrite", i), bus.ID_EX_RegWrite, tbl[i].e_regw);
      check($sformatf("row%0d_memread", i), bus.ID_EX_MemRead, tbl[i].e_mr);
      check($sformatf("row%0d_rs", i), bus.ID_EX_RegisterRs, tbl[i].e_rs);
      check($sformatf("row%0d_rt", i), bus.ID_EX_RegisterRt, tbl[i].e_rt);
      check($sformatf("row%0d_rd", i), bus.ID_EX_RegisterRd, tbl[i].e_rd);
    end

    // Asynchronous reset in the middle of a load-use stall
    do_reset();
    do_cycle(1'b0, 1'b0, CTL_LW, 5'd1, 5'd2, 5'd0, 32'h11, 32'h22, 32'h33, s, p);
    @(negedge clk);
    drive(1'b0, 1'b0, CTL_ADD, 5'd2, 5'd4, 5'd3, 32'h44, 32'h55, 32'h66);
    #1 check("midstall_stall_before", stall, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("midstall_ex_regs", dut_vec(), 119'd0);
    check("midstall_pc_write", pcw, 1'b1);
    check("midstall_if_id_write", ifw, 1'b1);
    check("midstall_stall", stall, 1'b0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Random stimulus against the model; small register range makes hazards common
    do_reset();
    for (int i = 0; i < 500; i++) begin
      do_cycle($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
               8'($urandom_range(0, 255)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
               $urandom, $urandom, $urandom, s, p);
    end

`ifdef HAZARD_PERF_CNT_EN
    // Five load-use pairs and two flushes, then counter wrap
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b0, 1'b0, CTL_LW,  5'd1, 5'd2, 5'd0, $urandom, $urandom, $urandom, s, p);
      do_cycle(1'b0, 1'b0, CTL_ADD, 5'd2, 5'd4, 5'd3, $urandom, $urandom, $urandom, s, p);
      do_cycle(1'b0, 1'b0, CTL_ADD, 5'd2, 5'd4, 5'd3, $urandom, $urandom, $urandom, s, p);
    end
    do_cycle(1'b0, 1'b1, CTL_NOP, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, s, p);
    do_cycle(1'b0, 1'b1, CTL_NOP, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, s, p);
    check("cnt_stall_five", stall_cnt, 32'd5);
    check("cnt_flush_two", flush_cnt, 32'd2);
    force dut.stall_cnt_o = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt_o;
    m_scnt = 32'hFFFF_FFFF;
    do_cycle(1'b0, 1'b0, CTL_LW,  5'd1, 5'd2, 5'd0, $urandom, $urandom, $urandom, s, p);
    do_cycle(1'b0, 1'b0, CTL_ADD, 5'd2, 5'd4, 5'd3, $urandom, $urandom, $urandom, s, p);
    check("cnt_stall_wrap", stall_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
